// File: rtl/funnel_stim_gen.sv
// funnel_stim_gen
//   Pseudo-random single-channel toggle generator for the NOR funnel inputs.
//   A run issues num_events toggles; each toggle lands gap+1 cycles after the
//   previous one (or after the start edge), where gap = min_gap + (lfsr[7:0] & gap_mask)
//   and the toggled channel is lfsr[15:12]. The LFSR steps on start and on each fire.
// Ports
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   start_i, seed_load_i      run request / seed load, honoured in IDLE only
//   seed_i                    seed value (zero is replaced by SEED)
//   min_gap_i, gap_mask_i     spacing terms, latched at start
//   num_events_i              toggles per run, latched at start
//   busy_o, done_o            run in progress / one-cycle end-of-run pulse
//   stim_out_o                funnel inputs
//   event_valid_o, event_ch_o strobe and channel of the toggle issued this cycle
//   event_cnt_o               toggles issued in the current run
module funnel_stim_gen #(
    parameter int          N_CH   = 16,
    parameter int          LFSR_W = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              seed_load_i,
    input  logic [15:0]       seed_i,
    input  logic [7:0]        min_gap_i,
    input  logic [7:0]        gap_mask_i,
    input  logic [15:0]       num_events_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_CH-1:0]   stim_out_o,
    output logic              event_valid_o,
    output logic [3:0]        event_ch_o,
    output logic [15:0]       event_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [LFSR_W-1:0] POLY    = 16'hB400;
    localparam logic [3:0]        CH_MASK = 4'(N_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        mg_q, mg_d, gm_q, gm_d;
    logic [15:0]       num_q, num_d;
    logic              busy_q, busy_d, done_q, done_d, ev_q, ev_d;
    logic [N_CH-1:0]   stim_q, stim_d;
    logic [3:0]        ch_q, ch_d, ch_cur;
    logic [15:0]       ecnt_q, ecnt_d, ecnt_inc;
    logic [8:0]        gap_start, gap_run;

    assign lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    assign ch_cur    = lfsr_q[15:12] & CH_MASK;
    assign ecnt_inc  = ecnt_q + 16'd1;
    // Start uses the live inputs; later fires use the values latched at start.
    assign gap_start = {1'b0, min_gap_i} + {1'b0, lfsr_q[7:0] & gap_mask_i};
    assign gap_run   = {1'b0, mg_q} + {1'b0, lfsr_q[7:0] & gm_q};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mg_d    = mg_q;
        gm_d    = gm_q;
        num_d   = num_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ev_d    = 1'b0;
        stim_d  = stim_q;
        ch_d    = ch_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load_i) begin
                    lfsr_d = (seed_i == '0) ? SEED : seed_i;
                end else if (start_i) begin
                    if (num_events_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mg_d    = min_gap_i;
                        gm_d    = gap_mask_i;
                        num_d   = num_events_i;
                        stim_d  = '0;
                        ecnt_d  = '0;
                        cnt_d   = gap_start;
                        lfsr_d  = lfsr_nxt;
                        busy_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 9'd1;
                end else begin
                    stim_d = stim_q ^ ({{(N_CH-1){1'b0}}, 1'b1} << ch_cur);
                    ev_d   = 1'b1;
                    ch_d   = ch_cur;
                    ecnt_d = ecnt_inc;
                    lfsr_d = lfsr_nxt;
                    cnt_d  = gap_run;
                    if (ecnt_inc == num_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            mg_q    <= '0;
            gm_q    <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ev_q    <= 1'b0;
            stim_q  <= '0;
            ch_q    <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mg_q    <= mg_d;
            gm_q    <= gm_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ev_q    <= ev_d;
            stim_q  <= stim_d;
            ch_q    <= ch_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stim_out_o    = stim_q;
    assign event_valid_o = ev_q;
    assign event_ch_o    = ch_q;
    assign event_cnt_o   = ecnt_q;

endmodule

// File: tb/tb_funnel_stim_gen.sv
// tb_funnel_stim_gen
//   Directed and random runs of funnel_stim_gen checked against an event-list
//   reference model: each run is expanded up front into a list of fire edges and
//   channels, then the DUT is compared edge by edge.
module tb_funnel_stim_gen;

    localparam int          N_CH = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n, start, seed_load;
    logic [15:0] seed, num_events;
    logic [7:0]  min_gap, gap_mask;
    logic        busy, done, event_valid;
    logic [15:0] stim_out, event_cnt;
    logic [3:0]  event_ch;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          obs_edge[$];
    int          obs_ch[$];

    always #5 clk = ~clk;

    funnel_stim_gen #(.N_CH(N_CH), .LFSR_W(16), .SEED(SEED)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .seed_load_i(seed_load),
        .seed_i(seed), .min_gap_i(min_gap), .gap_mask_i(gap_mask),
        .num_events_i(num_events), .busy_o(busy), .done_o(done),
        .stim_out_o(stim_out), .event_valid_o(event_valid),
        .event_ch_o(event_ch), .event_cnt_o(event_cnt)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed = s; seed_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr = (s == 16'h0) ? SEED : s;
    endtask

    // abort_at > 0: reset is applied at that edge. disturb: start/seed_load/params
    // are wiggled during edges 3..4 of the run.
    task automatic run(input int n, input logic [7:0] mg, input logic [7:0] gm,
                       input int abort_at, input bit disturb, input bit spacing);
        int fe[$];
        int fc[$];
        logic [15:0] l, exp_stim, exp_cnt;
        int t, gap, last, idx, prev;
        bit exp_v;
        l   = m_lfsr;
        gap = int'(mg) + int'(l[7:0] & gm);
        l   = lfsr_step(l);
        t   = gap + 1;
        for (int k = 0; k < n; k++) begin
            fe.push_back(t);
            fc.push_back(int'(l[15:12]) & (N_CH - 1));
            gap = int'(mg) + int'(l[7:0] & gm);
            l   = lfsr_step(l);
            t  += gap + 1;
        end
        last = fe[n-1];
        obs_edge.delete();
        obs_ch.delete();
        exp_stim = 16'h0; exp_cnt = 16'h0; idx = 0; prev = -1;

        @(negedge clk);
        min_gap = mg; gap_mask = gm; num_events = 16'(n); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("e0_busy", 32'(busy), 32'd1);
        chk("e0_stim", 32'(stim_out), 32'd0);
        chk("e0_cnt", 32'(event_cnt), 32'd0);
        chk("e0_valid", 32'(event_valid), 32'd0);

        for (int e = 1; e <= last + 3; e++) begin
            if (abort_at == e) rst_n = 1'b0;
            if (disturb && e == 3) begin
                start = 1'b1; seed_load = 1'b1; seed = 16'($urandom);
                min_gap = 8'($urandom); gap_mask = 8'hFF; num_events = 16'd1;
            end
            if (disturb && e == 5) begin
                start = 1'b0; seed_load = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (abort_at == e) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_stim", 32'(stim_out), 32'd0);
                chk("rst_valid", 32'(event_valid), 32'd0);
                chk("rst_ch", 32'(event_ch), 32'd0);
                chk("rst_cnt", 32'(event_cnt), 32'd0);
                rst_n = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("post_rst_done", 32'(done), 32'd0);
                    chk("post_rst_busy", 32'(busy), 32'd0);
                end
                m_lfsr = SEED;
                return;
            end
            exp_v = 1'b0;
            if (idx < n && fe[idx] == e) begin
                exp_v = 1'b1;
                exp_stim ^= 16'(1) << fc[idx];
                exp_cnt++;
            end
            chk("valid", 32'(event_valid), 32'(exp_v));
            if (exp_v) chk("ch", 32'(event_ch), 32'(fc[idx]));
            if (exp_v) idx++;
            chk("stim", 32'(stim_out), 32'(exp_stim));
            chk("cnt", 32'(event_cnt), 32'(exp_cnt));
            chk("busy", 32'(busy), (e <= last) ? 32'd1 : 32'd0);
            chk("done", 32'(done), (e == last + 1) ? 32'd1 : 32'd0);
            if (event_valid) begin
                if (spacing && prev >= 0) begin
                    chk("spacing_lo", 32'(e - prev >= 3), 32'd1);
                    chk("spacing_hi", 32'(e - prev <= 34), 32'd1);
                end
                prev = e;
                obs_edge.push_back(e);
                obs_ch.push_back(int'(event_ch));
            end
        end
        m_lfsr = l;
    endtask

    initial begin
        int cap_edge[$];
        int cap_ch[$];
        logic [15:0] held;
        rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 16'h0;
        min_gap = 8'h0; gap_mask = 8'h0; num_events = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stim", 32'(stim_out), 32'd0);
        chk("reset_valid", 32'(event_valid), 32'd0);
        chk("reset_cnt", 32'(event_cnt), 32'd0);
        rst_n = 1'b1;
        m_lfsr = SEED;

        // 1) directed three-event run from seed 1
        load_seed(16'h0001);
        run(3, 8'd3, 8'h00, 0, 1'b0, 1'b0);
        chk("t1_nev", 32'(obs_edge.size()), 32'd3);
        if (obs_edge.size() == 3) begin
            chk("t1_edge0", 32'(obs_edge[0]), 32'd4);
            chk("t1_edge1", 32'(obs_edge[1]), 32'd8);
            chk("t1_edge2", 32'(obs_edge[2]), 32'd12);
            chk("t1_ch0", 32'(obs_ch[0]), 32'd11);
            chk("t1_ch1", 32'(obs_ch[1]), 32'd5);
            chk("t1_ch2", 32'(obs_ch[2]), 32'd2);
        end
        chk("t1_hold_stim", 32'(stim_out), 32'h0824);
        chk("t1_hold_cnt", 32'(event_cnt), 32'd3);

        // 2) zero-event start: single done pulse, outputs held
        held = stim_out;
        @(negedge clk);
        num_events = 16'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_stim", 32'(stim_out), 32'(held));
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t2_done_off", 32'(done), 32'd0);
            chk("t2_busy_off", 32'(busy), 32'd0);
            chk("t2_stim_held", 32'(stim_out), 32'(held));
        end

        // seed_load wins over start in the same cycle
        @(negedge clk);
        seed = 16'h1234; seed_load = 1'b1; start = 1'b1; num_events = 16'd5;
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        m_lfsr = 16'h1234;
        chk("sl_prio_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("sl_prio_busy2", 32'(busy), 32'd0);
        run(4, 8'd1, 8'h03, 0, 1'b0, 1'b0);

        // 3) zero seed maps to SEED, back-to-back fires
        load_seed(16'h0000);
        run(2, 8'd0, 8'h00, 0, 1'b0, 1'b0);
        chk("t3_nev", 32'(obs_edge.size()), 32'd2);
        if (obs_edge.size() == 2) begin
            chk("t3_edge0", 32'(obs_edge[0]), 32'd1);
            chk("t3_edge1", 32'(obs_edge[1]), 32'd2);
        end

        // 4) reset mid-run, then replay from SEED
        load_seed(16'h0001);
        run(3, 8'd3, 8'h00, 6, 1'b0, 1'b0);
        run(3, 8'd3, 8'h00, 0, 1'b0, 1'b0);

        // 5) disturbed run equals undisturbed run from the same seed
        load_seed(16'hBEEF);
        run(4, 8'd3, 8'h07, 0, 1'b0, 1'b0);
        cap_edge = obs_edge;
        cap_ch   = obs_ch;
        load_seed(16'hBEEF);
        run(4, 8'd3, 8'h07, 0, 1'b1, 1'b0);
        chk("t5_len", 32'(obs_edge.size()), 32'(cap_edge.size()));
        if (obs_edge.size() == cap_edge.size()) begin
            for (int k = 0; k < obs_edge.size(); k++) begin
                chk("t5_edge", 32'(obs_edge[k]), 32'(cap_edge[k]));
                chk("t5_ch", 32'(obs_ch[k]), 32'(cap_ch[k]));
            end
        end

        // 6) long random run
        load_seed(16'($urandom));
        run(1000, 8'd2, 8'h1F, 0, 1'b0, 1'b1);
        chk("t6_nev", 32'(obs_edge.size()), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
